pim_buf_dma: RTL and testbench

PIM_BUF_DMA -- requirements
Module: pim_buf_dma

---
 rtl/pim_buf_dma.sv | 145 ++++++++++++++
 tb/tb_pim_buf_dma.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pim_buf_dma.sv
// Command-driven DMA between a 32-bit word stream and a byte-addressed buffer.
// Optional macro PIM_DMA_BOUNDS_CHECK_EN rejects commands that would run past MEM_DEPTH.
module pim_buf_dma #(
    parameter int MEM_DEPTH      = 28672,
    parameter int MEM_ADDR_WIDTH = 15,
    parameter int LEN_WIDTH      = 13
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_dir,
    input  logic [31:0]          i_cmd_addr,
    input  logic [LEN_WIDTH-1:0] i_cmd_len,
    input  logic                 i_s_valid,
    output logic                 o_s_ready,
    input  logic [31:0]          i_s_data,
    output logic                 o_m_valid,
    input  logic                 i_m_ready,
    output logic [31:0]          o_m_data,
    output logic [31:0]          o_buf_addr,
    output logic [31:0]          o_buf_wr_data,
    output logic [3:0]           o_buf_size,
    output logic                 o_buf_write,
    output logic                 o_buf_read,
    input  logic [31:0]          i_buf_rd_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2, DONE = 2'd3} state_t;

    state_t                    state_r, next_state_s;
    logic [MEM_ADDR_WIDTH-1:0] addr_r;
    logic [LEN_WIDTH-1:0]      rem_r;
    logic                      inflight_r;
    logic [31:0]               fifo_r [0:1];
    logic                      wr_ptr_r, rd_ptr_r;
    logic [1:0]                count_r;
    logic                      err_r;

    logic                      accept_s, wr_hs_s, pop_s, push_s, rd_issue_s, bad_s;
    logic [2:0]                occ_s;

    assign accept_s = i_cmd_valid && (state_r == IDLE);
    assign wr_hs_s  = (state_r == WR) && i_s_valid;
    assign pop_s    = (state_r == RD) && (count_r != 2'd0) && i_m_ready;
    assign push_s   = inflight_r;

    // Occupancy as it will stand after this cycle's pop, so a draining FIFO keeps one read per cycle.
    assign occ_s      = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign rd_issue_s = (state_r == RD) && (rem_r != {LEN_WIDTH{1'b0}}) && (occ_s < 3'd2);

`ifdef PIM_DMA_BOUNDS_CHECK_EN
    assign bad_s = ({{(32-MEM_ADDR_WIDTH){1'b0}}, i_cmd_addr[MEM_ADDR_WIDTH-1:2], 2'b00}
                    + {{(30-LEN_WIDTH){1'b0}}, i_cmd_len, 2'b00}) > 32'(MEM_DEPTH);
`else
    assign bad_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_r <= IDLE;
        else       state_r <= next_state_s;
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s)                                       next_state_s = IDLE;
                else if (bad_s || (i_cmd_len == {LEN_WIDTH{1'b0}})) next_state_s = DONE;
                else if (i_cmd_dir)                                  next_state_s = RD;
                else                                                 next_state_s = WR;
            end
            WR: begin
                if (wr_hs_s && (rem_r == {{(LEN_WIDTH-1){1'b0}}, 1'b1})) next_state_s = DONE;
                else                                                       next_state_s = WR;
            end
            RD: begin
                if ((rem_r == {LEN_WIDTH{1'b0}}) && !inflight_r && (count_r == 2'd0)) next_state_s = DONE;
                else                                                                   next_state_s = RD;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Address/length counters, read-in-flight flag and error latch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_r     <= {MEM_ADDR_WIDTH{1'b0}};
            rem_r      <= {LEN_WIDTH{1'b0}};
            inflight_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            inflight_r <= rd_issue_s;
            if (accept_s) begin
                addr_r <= {i_cmd_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
                rem_r  <= i_cmd_len;
                err_r  <= bad_s;
            end else if (wr_hs_s || rd_issue_s) begin
                addr_r <= addr_r + MEM_ADDR_WIDTH'(32'd4);
                rem_r  <= rem_r - LEN_WIDTH'(32'd1);
            end
        end
    end

    // Two-entry read FIFO; read data lands one cycle after the strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fifo_r[0] <= 32'd0;
            fifo_r[1] <= 32'd0;
            wr_ptr_r  <= 1'b0;
            rd_ptr_r  <= 1'b0;
            count_r   <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= i_buf_rd_data;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= ~rd_ptr_r;
            count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Output decode.
    always_comb begin
        o_cmd_ready   = (state_r == IDLE);
        o_busy        = (state_r == WR) || (state_r == RD);
        o_done        = (state_r == DONE);
        o_err         = (state_r == DONE) && err_r;
        o_s_ready     = (state_r == WR);
        o_buf_write   = wr_hs_s;
        o_buf_read    = rd_issue_s;
        o_buf_addr    = {{(32-MEM_ADDR_WIDTH){1'b0}}, addr_r[MEM_ADDR_WIDTH-1:2], 2'b00};
        o_buf_size    = (wr_hs_s || rd_issue_s) ? 4'b1111 : 4'b0000;
        o_buf_wr_data = (state_r == WR) ? i_s_data : 32'd0;
        o_m_valid     = (count_r != 2'd0);
        o_m_data      = (count_r != 2'd0) ? fifo_r[rd_ptr_r] : 32'd0;
    end

endmodule

// File: tb/tb_pim_buf_dma.sv
// Directed bench for pim_buf_dma with a one-cycle-latency buffer model.
module tb_pim_buf_dma;

    logic        i_clk = 1'b0, i_rst = 1'b1;
    logic        i_cmd_valid = 1'b0, i_cmd_dir = 1'b0;
    logic [31:0] i_cmd_addr = 32'd0;
    logic [12:0] i_cmd_len = 13'd0;
    logic        i_s_valid = 1'b0, i_m_ready = 1'b0;
    logic [31:0] i_s_data = 32'd0, i_buf_rd_data = 32'd0;
    logic        o_cmd_ready, o_s_ready, o_m_valid, o_buf_write, o_buf_read, o_busy, o_done, o_err;
    logic [31:0] o_m_data, o_buf_addr, o_buf_wr_data;
    logic [3:0]  o_buf_size;
    logic [31:0] mem [0:8191];
    int          n_checks = 0, n_errors = 0;

    pim_buf_dma dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_dir(i_cmd_dir),
        .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
        .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data),
        .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_data(o_m_data),
        .o_buf_addr(o_buf_addr), .o_buf_wr_data(o_buf_wr_data), .o_buf_size(o_buf_size),
        .o_buf_write(o_buf_write), .o_buf_read(o_buf_read), .i_buf_rd_data(i_buf_rd_data),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    // Buffer model: write on strobe, read data returned on the following cycle.
    always @(posedge i_clk) begin
        if (o_buf_write) mem[o_buf_addr[14:2]] <= o_buf_wr_data;
        if (o_buf_read)  i_buf_rd_data <= mem[o_buf_addr[14:2]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_flags"}, {24'd0, o_cmd_ready, o_s_ready, o_m_valid, o_buf_write,
                                   o_buf_read, o_busy, o_done, o_err}, 32'h0000_0080);
        check_eq({tag, "_size"}, {28'd0, o_buf_size}, 32'd0);
        check_eq({tag, "_addr"}, o_buf_addr, 32'd0);
        check_eq({tag, "_mdata"}, o_m_data, 32'd0);
        check_eq({tag, "_wdata"}, o_buf_wr_data, 32'd0);
    endtask

    // Presents a command at a negedge; returns at the negedge after acceptance.
    task automatic send_cmd(input logic dir, input logic [31:0] addr, input int len);
        check_eq("cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        i_cmd_valid = 1'b1; i_cmd_dir = dir; i_cmd_addr = addr; i_cmd_len = 13'(len);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input logic [31:0] d0,
                            input logic [31:0] exp_addr);
        send_cmd(1'b0, addr, len);
        check_eq("wr_busy", {30'd0, o_busy, o_s_ready}, 32'd3);
        for (int i = 0; i < len; i++) begin
            i_s_valid = 1'b1; i_s_data = d0 + 32'(i);
            #1;
            check_eq("wr_strobe", {27'd0, o_buf_write, o_buf_size}, 32'h1F);
            check_eq("wr_addr", o_buf_addr, exp_addr + 32'(4 * i));
            check_eq("wr_data", o_buf_wr_data, d0 + 32'(i));
            @(negedge i_clk);
        end
        i_s_valid = 1'b0;
        #1;
        check_eq("wr_done", {30'd0, o_done, o_err}, 32'd2);
        @(negedge i_clk);
        check_eq("wr_after", {30'd0, o_done, o_cmd_ready}, 32'd1);
    endtask

    task automatic read_collect(input logic [31:0] addr, input int len, input bit toggle,
                                input logic [31:0] d0, input int exp_first);
        logic [31:0] q[$];
        int occ = 0, inf = 0, ovf = 0, vmis = 0, aerr = 0, nrd = 0, first = -1, last = -1;
        bit pop, done_seen = 1'b0;
        send_cmd(1'b1, addr, len);
        for (int k = 0; k < 200; k++) begin
            i_m_ready = toggle ? ((k % 2) == 0) : 1'b1;
            #1;
            if (o_done) begin
                done_seen = 1'b1;
                break;
            end
            pop = o_m_valid && i_m_ready;
            if (o_m_valid !== (occ != 0)) vmis++;
            if (pop) begin
                q.push_back(o_m_data);
                if (first < 0) first = k;
                last = k;
            end
            if (o_buf_read) begin
                if (occ + inf - int'(pop) >= 2) ovf++;
                if (o_buf_addr !== addr + 32'(4 * nrd)) aerr++;
                nrd++;
            end
            occ = occ + inf - int'(pop);
            inf = int'(o_buf_read);
            @(negedge i_clk);
        end
        i_m_ready = 1'b0;
        check_eq("rd_done_seen", {31'd0, done_seen}, 32'd1);
        check_eq("rd_err", {31'd0, o_err}, 32'd0);
        check_eq("rd_count", 32'(q.size()), 32'(len));
        for (int i = 0; i < len && i < q.size(); i++) check_eq("rd_data", q[i], d0 + 32'(i));
        check_eq("rd_reads", 32'(nrd), 32'(len));
        check_eq("rd_overflow", 32'(ovf), 32'd0);
        check_eq("rd_valid_vs_occ", 32'(vmis), 32'd0);
        check_eq("rd_addr", 32'(aerr), 32'd0);
        if (exp_first >= 0) begin
            check_eq("rd_first_valid", 32'(first), 32'(exp_first));
            check_eq("rd_consecutive", 32'(last - first + 1), 32'(len));
        end
        @(negedge i_clk);
        check_eq("rd_after", {30'd0, o_done, o_cmd_ready}, 32'd1);
    endtask

    initial begin
        int popped;
        for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
        repeat (2) @(negedge i_clk);
        check_idle("reset");
        i_rst = 1'b0;
        @(negedge i_clk);

        // Writes then back-to-back read at 0x100.
        do_write(32'h0000_0100, 4, 32'hA0, 32'h0000_0100);
        read_collect(32'h0000_0100, 4, 1'b0, 32'hA0, 2);

        // Eight-word read against a 1010 ready pattern.
        do_write(32'h0000_0200, 8, 32'hB0, 32'h0000_0200);
        read_collect(32'h0000_0200, 8, 1'b1, 32'hB0, -1);

        // Stray stream handshakes outside a transfer, then a zero-length command.
        i_s_valid = 1'b1; i_m_ready = 1'b1;
        #1;
        check_eq("idle_ignore", {29'd0, o_s_ready, o_buf_write, o_m_valid}, 32'd0);
        @(negedge i_clk);
        send_cmd(1'b0, 32'h0000_0500, 0);
        #1;
        check_eq("len0_done", {28'd0, o_done, o_buf_write, o_buf_read, o_busy}, 32'd8);
        @(negedge i_clk);
        check_eq("len0_after", {30'd0, o_done, o_cmd_ready}, 32'd1);
        i_s_valid = 1'b0; i_m_ready = 1'b0;

`ifdef PIM_DMA_BOUNDS_CHECK_EN
        send_cmd(1'b0, 32'h8000_6FFE, 2);
        i_s_valid = 1'b1; i_s_data = 32'hD0;
        #1;
        check_eq("bounds_err", {29'd0, o_done, o_err, o_buf_write}, 32'd6);
        @(negedge i_clk);
        check_eq("bounds_after", {29'd0, o_done, o_err, o_cmd_ready}, 32'd1);
        i_s_valid = 1'b0;
`else
        do_write(32'h8000_6FFE, 2, 32'hD0, 32'h0000_6FFC);
`endif

        // Reset during a six-word read once two words have left.
        send_cmd(1'b1, 32'h0000_0100, 6);
        i_m_ready = 1'b1;
        popped = 0;
        for (int k = 0; k < 50 && popped < 2; k++) begin
            #1;
            if (o_m_valid) popped++;
            @(negedge i_clk);
        end
        check_eq("rst_popped", 32'(popped), 32'd2);
        i_s_valid = 1'b1;
        i_rst = 1'b1;
        #1;
        check_idle("midrst");
        @(negedge i_clk);
        check_idle("midrst_hold");
        i_rst = 1'b0; i_s_valid = 1'b0; i_m_ready = 1'b0;
        @(negedge i_clk);
        do_write(32'h0000_0400, 2, 32'hC0, 32'h0000_0400);
        read_collect(32'h0000_0400, 2, 1'b0, 32'hC0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
